// File: rtl/mvu_apb_csr_slave.sv
// APB3 slave with one MVU control/status/config register bank per hart, start pulses, busy/done tracking and irqs.
// Define MVU_CSR_PERF_EN to add a per-hart read-only CYCLES busy counter just past the config registers.
module mvu_apb_csr_slave #(
    parameter int          NUM_HARTS   = 8,
    parameter int          HART_W      = 3,
    parameter logic [11:0] CSR_BASE    = 12'hF20,
    parameter int          NUM_CFG     = 8,
    parameter int          WAIT_STATES = 0
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [HART_W+11:0]            paddr,
    input  logic                          psel,
    input  logic                          penable,
    input  logic                          pwrite,
    input  logic [31:0]                   pwdata,
    input  logic [3:0]                    pstrb,
    output logic [31:0]                   prdata,
    output logic                          pready,
    output logic                          pslverr,
    output logic [NUM_HARTS-1:0]          mvu_start,
    input  logic [NUM_HARTS-1:0]          mvu_done,
    output logic [NUM_HARTS*NUM_CFG*32-1:0] mvu_cfg,
    output logic [NUM_HARTS-1:0]          mvu_irq
);
    localparam int WC_W = (WAIT_STATES > 0) ? $clog2(WAIT_STATES + 1) : 1;
    localparam logic [WC_W-1:0]   WAIT_LIM = WAIT_STATES[WC_W-1:0];
    localparam logic [HART_W:0]   HART_LIM = NUM_HARTS[HART_W:0];
`ifdef MVU_CSR_PERF_EN
    localparam logic [11:0]       LAST_OFF = 12'(NUM_CFG + 2);
`else
    localparam logic [11:0]       LAST_OFF = 12'(NUM_CFG + 1);
`endif

    typedef enum logic {IDLE, ACCESS} state_t;

    state_t             state_reg;
    logic [HART_W-1:0]  hart_reg;
    logic [11:0]        off_reg;
    logic               write_reg;
    logic               range_err_reg;
    logic [31:0]        wdata_reg;
    logic [3:0]         strb_reg;
    logic [WC_W-1:0]    wait_cnt_reg;

    logic [HART_W-1:0]  dec_hart;
    logic [11:0]        dec_off;
    logic               dec_err;
    logic               pready_int;
    logic               commit;
    logic               sel_ctrl;
    logic               sel_stat;
    logic               busy_sel;
    logic               start_err;
    logic               cyc_wr_err;
    logic [31:0]        rdata;
    logic [NUM_HARTS-1:0] hart_hit;
    logic [NUM_HARTS-1:0] busy_vec;
    logic [NUM_HARTS-1:0] done_vec;
    logic [NUM_HARTS-1:0] irq_en_vec;
    logic [NUM_HARTS-1:0] start_vec;

    // Offset is relative to CSR_BASE with 12-bit wrap, so addresses below the base land far out of range.
    assign dec_hart = paddr[HART_W+11:12];
    assign dec_off  = paddr[11:0] - CSR_BASE;
    assign dec_err  = ({1'b0, dec_hart} >= HART_LIM) || (dec_off > LAST_OFF);

    assign pready_int = (state_reg == ACCESS) && psel && penable && (wait_cnt_reg == WAIT_LIM);
    assign commit     = pready_int && write_reg && !range_err_reg;
    assign sel_ctrl   = (off_reg == 12'd0);
    assign sel_stat   = (off_reg == 12'd1);
    assign busy_sel   = |(busy_vec & hart_hit);
    assign start_err  = write_reg && sel_ctrl && wdata_reg[0] && busy_sel;

`ifdef MVU_CSR_PERF_EN
    logic        sel_cyc;
    logic [31:0] cycles_arr [NUM_HARTS];
    assign sel_cyc    = (off_reg == LAST_OFF);
    assign cyc_wr_err = write_reg && sel_cyc;
`else
    assign cyc_wr_err = 1'b0;
`endif

    assign pready  = pready_int;
    assign pslverr = pready_int && (range_err_reg || start_err || cyc_wr_err);
    assign prdata  = (pready_int && !write_reg && !range_err_reg) ? rdata : 32'd0;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            hart_reg      <= '0;
            off_reg       <= '0;
            write_reg     <= 1'b0;
            range_err_reg <= 1'b0;
            wdata_reg     <= '0;
            strb_reg      <= '0;
            wait_cnt_reg  <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (psel) begin
                        hart_reg      <= dec_hart;
                        off_reg       <= dec_off;
                        write_reg     <= pwrite;
                        range_err_reg <= dec_err;
                        wdata_reg     <= pwdata;
                        strb_reg      <= pstrb;
                        wait_cnt_reg  <= '0;
                        state_reg     <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (!psel || pready_int) begin
                        state_reg <= IDLE;
                    end else if (penable) begin
                        wait_cnt_reg <= wait_cnt_reg + 1'b1;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    always_comb begin
        rdata = 32'd0;
        for (int h = 0; h < NUM_HARTS; h++) begin
            if (hart_hit[h]) begin
                if (sel_ctrl) rdata = {30'd0, irq_en_vec[h], 1'b0};
                if (sel_stat) rdata = {30'd0, done_vec[h], busy_vec[h]};
                for (int r = 0; r < NUM_CFG; r++) begin
                    if (off_reg == 12'(r + 2)) rdata = mvu_cfg[(h*NUM_CFG+r)*32 +: 32];
                end
`ifdef MVU_CSR_PERF_EN
                if (sel_cyc) rdata = cycles_arr[h];
`endif
            end
        end
    end

    genvar gi, gr;
    generate
        for (gi = 0; gi < NUM_HARTS; gi++) begin : g_hart
            logic busy_reg;
            logic done_reg;
            logic irq_en_reg;
            logic start_reg;
            logic wr_hit;
            logic start_go;

            assign hart_hit[gi] = (hart_reg == HART_W'(gi));
            assign wr_hit       = commit && hart_hit[gi];
            assign start_go     = wr_hit && sel_ctrl && wdata_reg[0] && !busy_reg;

            // A start and a done on the same edge leave the hart busy with DONE also set.
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    busy_reg   <= 1'b0;
                    done_reg   <= 1'b0;
                    irq_en_reg <= 1'b0;
                    start_reg  <= 1'b0;
                end else begin
                    start_reg <= start_go;
                    if (wr_hit && sel_ctrl) irq_en_reg <= wdata_reg[1];
                    if (start_go) busy_reg <= 1'b1;
                    else if (mvu_done[gi]) busy_reg <= 1'b0;
                    if (mvu_done[gi]) done_reg <= 1'b1;
                    else if (wr_hit && sel_stat && wdata_reg[1]) done_reg <= 1'b0;
                end
            end

            assign busy_vec[gi]   = busy_reg;
            assign done_vec[gi]   = done_reg;
            assign irq_en_vec[gi] = irq_en_reg;
            assign start_vec[gi]  = start_reg;

            for (gr = 0; gr < NUM_CFG; gr++) begin : g_cfg
                logic [31:0] cfg_reg;
                always_ff @(posedge clk) begin
                    if (!rst_n) begin
                        cfg_reg <= '0;
                    end else if (wr_hit && off_reg == 12'(gr + 2)) begin
                        for (int b = 0; b < 4; b++) begin
                            if (strb_reg[b]) cfg_reg[8*b +: 8] <= wdata_reg[8*b +: 8];
                        end
                    end
                end
                assign mvu_cfg[(gi*NUM_CFG+gr)*32 +: 32] = cfg_reg;
            end

`ifdef MVU_CSR_PERF_EN
            logic [31:0] cycles_reg;
            always_ff @(posedge clk) begin
                if (!rst_n || start_go) begin
                    cycles_reg <= '0;
                end else if (busy_reg && cycles_reg != 32'hFFFF_FFFF) begin
                    cycles_reg <= cycles_reg + 32'd1;
                end
            end
            assign cycles_arr[gi] = cycles_reg;
`endif
        end
    endgenerate

    assign mvu_start = start_vec;
    assign mvu_irq   = done_vec & irq_en_vec;

endmodule

// File: tb/tb_mvu_apb_csr_slave.sv
// Directed bench: a zero-wait instance and a WAIT_STATES=2 instance, expected APB responses queued per transfer.
module tb_mvu_apb_csr_slave;
    localparam int NH = 8;
    localparam int HW = 3;
    localparam int NC = 8;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [HW+11:0]  paddr = '0;
    logic            psel = 1'b0;
    logic            psel_ws = 1'b0;
    logic            penable = 1'b0;
    logic            pwrite = 1'b0;
    logic [31:0]     pwdata = '0;
    logic [3:0]      pstrb = '0;
    logic [31:0]     prdata, prdata_ws;
    logic            pready, pready_ws, pslverr, pslverr_ws;
    logic [NH-1:0]   mvu_start, mvu_start_ws, mvu_irq, mvu_irq_ws;
    logic [NH-1:0]   mvu_done = '0;
    logic [NH-1:0]   mvu_done_ws = '0;
    logic [NH*NC*32-1:0] mvu_cfg, mvu_cfg_ws;

    always #5 clk = ~clk;

    mvu_apb_csr_slave dut (
        .clk(clk), .rst_n(rst_n), .paddr(paddr), .psel(psel), .penable(penable),
        .pwrite(pwrite), .pwdata(pwdata), .pstrb(pstrb), .prdata(prdata), .pready(pready),
        .pslverr(pslverr), .mvu_start(mvu_start), .mvu_done(mvu_done), .mvu_cfg(mvu_cfg),
        .mvu_irq(mvu_irq)
    );

    mvu_apb_csr_slave #(.WAIT_STATES(2)) dut_ws (
        .clk(clk), .rst_n(rst_n), .paddr(paddr), .psel(psel_ws), .penable(penable),
        .pwrite(pwrite), .pwdata(pwdata), .pstrb(pstrb), .prdata(prdata_ws), .pready(pready_ws),
        .pslverr(pslverr_ws), .mvu_start(mvu_start_ws), .mvu_done(mvu_done_ws), .mvu_cfg(mvu_cfg_ws),
        .mvu_irq(mvu_irq_ws)
    );

    typedef struct {
        string       tag;
        logic [31:0] rdata;
        logic        err;
        logic        wr;
    } exp_t;

    exp_t sb[$];
    int checks = 0;
    int errors = 0;

    function automatic logic [HW+11:0] csr_addr(input int h, input int off);
        logic [11:0] a;
        a = 12'hF20 + 12'(off);
        return {HW'(h), a};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One APB transfer; the expectation is queued at drive time and popped on pready.
    task automatic apb(input bit ws, input bit wr, input logic [HW+11:0] addr, input logic [31:0] wdata,
                       input logic [3:0] strb, input logic [31:0] exp_rdata, input logic exp_err,
                       input string tag, input logic [NH-1:0] done_at_commit, output int waits);
        exp_t e;
        int n;
        sb.push_back('{tag, exp_rdata, exp_err, wr});
        @(posedge clk); #1;
        paddr = addr; pwrite = wr; pwdata = wdata; pstrb = strb; penable = 1'b0;
        if (ws) psel_ws = 1'b1; else psel = 1'b1;
        @(posedge clk); #1;
        penable = 1'b1;
        n = 0;
        @(negedge clk);
        while (!(ws ? pready_ws : pready) && n < 20) begin
            @(negedge clk);
            n++;
        end
        e = sb.pop_front();
        waits = n;
        checks++;
        assert (n < 20) else begin
            errors++;
            $error("FAIL %s_timeout: observed no pready expected pready within 20 cycles", e.tag);
        end
        if (n < 20) begin
            check({e.tag, "_pslverr"}, 32'(ws ? pslverr_ws : pslverr), 32'(e.err));
            if (!e.wr) check({e.tag, "_prdata"}, ws ? prdata_ws : prdata, e.rdata);
        end
        mvu_done = done_at_commit;
        @(posedge clk); #1;
        mvu_done = '0; psel = 1'b0; psel_ws = 1'b0; penable = 1'b0;
    endtask

    initial begin
        int w;
        logic [NH*NC*32-1:0] exp_cfg;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_pready", 32'(pready), 0);
        check("rst_pslverr", 32'(pslverr), 0);
        check("rst_prdata", prdata, 0);
        check("rst_start", 32'(mvu_start), 0);
        check("rst_irq", 32'(mvu_irq), 0);
        checks++;
        assert (mvu_cfg === '0) else begin
            errors++;
            $error("FAIL rst_cfg: observed nonzero expected 0");
        end
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Full-word config write and readback
        apb(0, 1, csr_addr(3, 2), 32'hDEADBEEF, 4'hF, 32'h0, 1'b0, "cfg_wr", '0, w);
        check("zero_wait", w, 0);
        apb(0, 0, csr_addr(3, 2), 32'h0, 4'h0, 32'hDEADBEEF, 1'b0, "cfg_rd", '0, w);
        exp_cfg = '0;
        exp_cfg[(3*NC+0)*32 +: 32] = 32'hDEADBEEF;
        checks++;
        assert (mvu_cfg === exp_cfg) else begin
            errors++;
            $error("FAIL cfg_vec: observed h3r0=%0h expected h3r0=%0h others 0", mvu_cfg[768 +: 32], exp_cfg[768 +: 32]);
        end

        // Byte-strobed write over zero
        apb(0, 1, csr_addr(2, 3), 32'h11223344, 4'b0101, 32'h0, 1'b0, "strb_wr", '0, w);
        apb(0, 0, csr_addr(2, 3), 32'h0, 4'h0, 32'h00220044, 1'b0, "strb_rd", '0, w);

        // Start, done, irq and W1C on hart 5
        apb(0, 1, csr_addr(5, 0), 32'h3, 4'hF, 32'h0, 1'b0, "start_wr", '0, w);
        @(negedge clk);
        check("start_pulse", 32'(mvu_start), 32'h20);
        @(negedge clk);
        check("start_one_cycle", 32'(mvu_start), 32'h0);
        apb(0, 0, csr_addr(5, 1), 32'h0, 4'h0, 32'h1, 1'b0, "status_busy", '0, w);
        @(posedge clk); #1;
        mvu_done = 8'h20;
        @(posedge clk); #1;
        mvu_done = '0;
        apb(0, 0, csr_addr(5, 1), 32'h0, 4'h0, 32'h2, 1'b0, "status_done", '0, w);
        @(negedge clk);
        check("irq_set", 32'(mvu_irq), 32'h20);
        apb(0, 1, csr_addr(5, 1), 32'h2, 4'hF, 32'h0, 1'b0, "status_w1c", '0, w);
        @(negedge clk);
        check("irq_clr", 32'(mvu_irq), 32'h0);

        // Error paths
        apb(0, 0, {3'd0, 12'hFFF}, 32'h0, 4'h0, 32'h0, 1'b1, "oob_rd", '0, w);
`ifdef MVU_CSR_PERF_EN
        apb(0, 0, csr_addr(0, NC + 2), 32'h0, 4'h0, 32'h0, 1'b0, "cycles_idle_rd", '0, w);
`else
        apb(0, 0, csr_addr(0, NC + 2), 32'h0, 4'h0, 32'h0, 1'b1, "past_cfg_rd", '0, w);
`endif
        apb(0, 1, csr_addr(0, NC + 3), 32'hFFFF_FFFF, 4'hF, 32'h0, 1'b1, "oob_wr", '0, w);
        apb(0, 1, csr_addr(1, 0), 32'h1, 4'hF, 32'h0, 1'b0, "start1_wr", '0, w);
        @(negedge clk);
        check("start1_pulse", 32'(mvu_start), 32'h02);
        apb(0, 1, csr_addr(1, 0), 32'h3, 4'hF, 32'h0, 1'b1, "busy_start_wr", '0, w);
        @(negedge clk);
        check("busy_no_pulse", 32'(mvu_start), 32'h0);
        apb(0, 0, csr_addr(1, 0), 32'h0, 4'h0, 32'h2, 1'b0, "irq_en_kept", '0, w);

        // START commit and mvu_done on the same edge for hart 4
        apb(0, 1, csr_addr(4, 0), 32'h1, 4'hF, 32'h0, 1'b0, "start_done_wr", 8'h10, w);
        @(negedge clk);
        check("start_done_pulse", 32'(mvu_start), 32'h10);
`ifdef MVU_CSR_PERF_EN
        repeat (8) @(posedge clk);
        apb(0, 0, csr_addr(4, NC + 2), 32'h0, 4'h0, 32'd10, 1'b0, "cycles_rd", '0, w);
        apb(0, 1, csr_addr(4, NC + 2), 32'h0, 4'hF, 32'h0, 1'b1, "cycles_wr", '0, w);
`endif
        apb(0, 0, csr_addr(4, 1), 32'h0, 4'h0, 32'h3, 1'b0, "status_start_done", '0, w);

        // Two wait states, then an aborted write
        apb(1, 1, csr_addr(0, 2), 32'h5A5A5A5A, 4'hF, 32'h0, 1'b0, "ws_wr", '0, w);
        check("ws_wait", w, 2);
        @(posedge clk); #1;
        paddr = csr_addr(0, 2); pwrite = 1'b1; pwdata = 32'hFFFF_FFFF; pstrb = 4'hF; psel_ws = 1'b1;
        @(posedge clk); #1;
        penable = 1'b1;
        @(negedge clk);
        check("ws_abort_notready", 32'(pready_ws), 0);
        @(posedge clk); #1;
        psel_ws = 1'b0; penable = 1'b0;
        apb(1, 0, csr_addr(0, 2), 32'h0, 4'h0, 32'h5A5A5A5A, 1'b0, "ws_abort_rd", '0, w);

        // Reset in the middle of a wait-stated transfer
        @(posedge clk); #1;
        paddr = csr_addr(0, 2); pwrite = 1'b1; pwdata = 32'h1234_5678; pstrb = 4'hF; psel_ws = 1'b1;
        @(posedge clk); #1;
        penable = 1'b1; rst_n = 1'b0;
        @(posedge clk); #1;
        psel_ws = 1'b0; penable = 1'b0;
        @(negedge clk);
        check("rst_mid_pready", 32'(pready_ws), 0);
        check("rst_mid_cfg_ws", mvu_cfg_ws[31:0], 0);
        check("rst_mid_cfg", mvu_cfg[768 +: 32], 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        apb(0, 0, csr_addr(4, 1), 32'h0, 4'h0, 32'h0, 1'b0, "status_after_rst", '0, w);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
